// File: rtl/ctrl_pkg.sv
// Shared definitions for the stack-machine controller: state encoding, opcodes, ALU ops.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_POP_A  = 4'd3,
    S_POP_B  = 4'd4,
    S_EXEC   = 4'd5,
    S_WB     = 4'd6,
    S_MEM_RD = 4'd7,
    S_PUSH_M = 4'd8,
    S_MEM_WR = 4'd9,
    S_JUMP   = 4'd10,
    S_TOS_RD = 4'd11,
    S_BRZ    = 4'd12
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/controller.sv
// Multicycle stack-machine control FSM (Moore outputs decoded from state).
// Optional retired-instruction counter enabled by CTRL_PERF_EN.
//
// state  | meaning
// IDLE   | post-reset, all outputs low
// FETCH  | read instruction into IR, PC <= PC+1
// DECODE | opcode valid, branch on it
// POP_A  | pop top of stack into A
// POP_B  | pop next entry into B
// EXEC   | ALU on A/B, op from opcode[1:0]
// WB     | push ALU result
// MEM_RD | read memory at instruction[4:0]
// PUSH_M | push MDR
// MEM_WR | store A to memory at instruction[4:0]
// JUMP   | PC <= jump address
// TOS_RD | load zero register from top of stack
// BRZ    | conditional PC <= jump address
module controller
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  output logic        IR_write,
  output logic        ld_A,
  output logic        ld_B,
  output logic        mem_read,
  output logic        mem_write,
  output logic        push,
  output logic        pop,
  output logic        tos,
  output logic        IorD,
  output logic        MtoS,
  output logic        src_A,
  output logic        src_B,
  output logic        pc_src,
  output logic        pc_write_cond,
  output logic        pc_write,
  output logic [1:0]  alu_op
`ifdef CTRL_PERF_EN
  ,
  output logic [15:0] instr_count
`endif
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = S_FETCH;
    IR_write      = 1'b0;
    ld_A          = 1'b0;
    ld_B          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    tos           = 1'b0;
    IorD          = 1'b0;
    MtoS          = 1'b0;
    src_A         = 1'b0;
    src_B         = 1'b0;
    pc_src        = 1'b0;
    pc_write_cond = 1'b0;
    pc_write      = 1'b0;
    alu_op        = ALU_ADD;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
        IR_write = 1'b1;
        pc_src   = 1'b1;
        pc_write = 1'b1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_PUSH: w_next = S_MEM_RD;
          OP_JMP:  w_next = S_JUMP;
          OP_JZ:   w_next = S_TOS_RD;
          default: w_next = S_POP_A;
        endcase
      end
      S_POP_A: begin
        pop  = 1'b1;
        ld_A = 1'b1;
        case (opcode)
          OP_NOT:  w_next = S_EXEC;
          OP_POP:  w_next = S_MEM_WR;
          default: w_next = S_POP_B;
        endcase
      end
      S_POP_B: begin
        pop    = 1'b1;
        ld_B   = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        // opcode is held in IR, so the low bits select the ALU function directly
        src_A  = 1'b1;
        src_B  = 1'b1;
        alu_op = opcode[1:0];
        w_next = S_WB;
      end
      S_WB: begin
        MtoS = 1'b1;
        push = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        w_next   = S_PUSH_M;
      end
      S_PUSH_M: push = 1'b1;
      S_MEM_WR: mem_write = 1'b1;
      S_JUMP:   pc_write = 1'b1;
      S_TOS_RD: begin
        tos    = 1'b1;
        w_next = S_BRZ;
      end
      S_BRZ:    pc_write_cond = 1'b1;
      default:  w_next = S_FETCH;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic        w_retire;
  logic [15:0] r_instr_count;

  // An instruction retires when its final state hands control back to FETCH
  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_WB) || (r_state == S_PUSH_M) || (r_state == S_MEM_WR) ||
                     (r_state == S_JUMP) || (r_state == S_BRZ));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_instr_count <= 16'h0000;
    else if (w_retire) r_instr_count <= r_instr_count + 16'd1;
  end

  assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_controller.sv
// Directed-vector bench for controller; checks every cycle's outputs against hand-built vectors.
module tb_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic IR_write, ld_A, ld_B, mem_read, mem_write, push, pop, tos;
  logic IorD, MtoS, src_A, src_B, pc_src, pc_write_cond, pc_write;
  logic [1:0] alu_op;
`ifdef CTRL_PERF_EN
  logic [15:0] instr_count;
`endif

  controller dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .IR_write(IR_write), .ld_A(ld_A), .ld_B(ld_B), .mem_read(mem_read),
    .mem_write(mem_write), .push(push), .pop(pop), .tos(tos),
    .IorD(IorD), .MtoS(MtoS), .src_A(src_A), .src_B(src_B), .pc_src(pc_src),
    .pc_write_cond(pc_write_cond), .pc_write(pc_write), .alu_op(alu_op)
`ifdef CTRL_PERF_EN
    , .instr_count(instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IR_write, ld_A, ld_B, mem_read, mem_write, push, pop, tos,
  //  IorD, MtoS, src_A, src_B, pc_src, pc_write_cond, pc_write, alu_op[1:0]}
  logic [16:0] w_out;
  assign w_out = {IR_write, ld_A, ld_B, mem_read, mem_write, push, pop, tos,
                  IorD, MtoS, src_A, src_B, pc_src, pc_write_cond, pc_write, alu_op};

  localparam logic [16:0] V_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] V_FETCH  = 17'b1_0_0_1_0_0_0_0_1_0_0_0_1_0_1_00;
  localparam logic [16:0] V_POP_A  = 17'b0_1_0_0_0_0_1_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] V_POP_B  = 17'b0_0_1_0_0_0_1_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] V_EXEC   = 17'b0_0_0_0_0_0_0_0_0_0_1_1_0_0_0_00;
  localparam logic [16:0] V_WB     = 17'b0_0_0_0_0_1_0_0_0_1_0_0_0_0_0_00;
  localparam logic [16:0] V_MEM_RD = 17'b0_0_0_1_0_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] V_PUSH_M = 17'b0_0_0_0_0_1_0_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] V_MEM_WR = 17'b0_0_0_0_1_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] V_JUMP   = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_1_00;
  localparam logic [16:0] V_TOS_RD = 17'b0_0_0_0_0_0_0_1_0_0_0_0_0_0_0_00;
  localparam logic [16:0] V_BRZ    = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_1_0_00;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle to its last cycle, checking each cycle.
  task automatic run_instr(input logic [2:0] op, input string name);
    logic [16:0] seq [6];
    int len;
    case (op)
      3'b000, 3'b001, 3'b010: begin
        seq = '{V_FETCH, V_ZERO, V_POP_A, V_POP_B, V_EXEC | {15'd0, op[1:0]}, V_WB};
        len = 6;
      end
      3'b011: begin
        seq = '{V_FETCH, V_ZERO, V_POP_A, V_EXEC | 17'b11, V_WB, V_ZERO};
        len = 5;
      end
      3'b100: begin seq = '{V_FETCH, V_ZERO, V_MEM_RD, V_PUSH_M, V_ZERO, V_ZERO}; len = 4; end
      3'b101: begin seq = '{V_FETCH, V_ZERO, V_POP_A, V_MEM_WR, V_ZERO, V_ZERO}; len = 4; end
      3'b110: begin seq = '{V_FETCH, V_ZERO, V_JUMP, V_ZERO, V_ZERO, V_ZERO};   len = 3; end
      default: begin seq = '{V_FETCH, V_ZERO, V_TOS_RD, V_BRZ, V_ZERO, V_ZERO}; len = 4; end
    endcase
    opcode = op;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s cyc%0d", name, i), {15'd0, w_out}, {15'd0, seq[i]});
      check($sformatf("%s excl%0d", name, i),
            {31'd0, (push & pop) | (mem_read & mem_write)}, 32'd0);
    end
  endtask

  initial begin
    rst    = 1'b0;
    opcode = 3'b000;
    repeat (2) @(negedge clk);
    check("reset outputs", {15'd0, w_out}, 32'd0);
`ifdef CTRL_PERF_EN
    check("reset count", {16'd0, instr_count}, 32'd0);
`endif
    rst = 1'b1;
    #1;
    check("idle outputs", {15'd0, w_out}, 32'd0);

    run_instr(3'b000, "ADD1");
    run_instr(3'b000, "ADD2");
    run_instr(3'b000, "ADD3");
    run_instr(3'b110, "JMP1");
    run_instr(3'b110, "JMP2");
    run_instr(3'b011, "NOT");
`ifdef CTRL_PERF_EN
    check("count after 5", {16'd0, instr_count}, 32'd5);
    force dut.r_instr_count = 16'hFFFF;
    #1;
    release dut.r_instr_count;
    check("preload", {16'd0, instr_count}, 32'h0000FFFF);
`endif
    run_instr(3'b001, "SUB");
`ifdef CTRL_PERF_EN
    check("count wrap", {16'd0, instr_count}, 32'd0);
`endif
    run_instr(3'b010, "AND");
    run_instr(3'b100, "PUSH");
    run_instr(3'b101, "POP");
    run_instr(3'b111, "JZ");
    run_instr(3'b110, "JMP3");

    // Reset asserted in the middle of EXEC
    opcode = 3'b000;
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset exec", {15'd0, w_out}, {15'd0, V_EXEC});
    #2;
    rst = 1'b0;
    #1;
    check("async reset", {15'd0, w_out}, 32'd0);
`ifdef CTRL_PERF_EN
    check("async reset count", {16'd0, instr_count}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset held", {15'd0, w_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle after reset", {15'd0, w_out}, 32'd0);
    run_instr(3'b011, "NOT2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
REQ-002 opcode  in  3  instruction[7:5] from IR; valid from the DECODE state onward.
REQ-003 Outputs SHALL be, each 1 bit unless noted:
- IR_write, ld_A, ld_B, mem_read, mem_write, push, pop, tos.
- IorD (1=PC, 0=instruction[4:0]); MtoS (1=ALU reg, 0=MDR).
- src_A (1=A, 0=PC); src_B (1=B, 0=constant 1); pc_src (1=ALU result, 0=jump address).
- pc_write_cond, pc_write.
- alu_op  out  2.
REQ-004 instr_count  out  16  retired-instruction count; present only under CTRL_PERF_EN.

Function
REQ-005 The block SHALL be a Moore FSM; every output SHALL be a pure decode of the current state, and opcode SHALL affect only the next state.
REQ-006 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
REQ-007 alu_op SHALL be: 00 add, 01 sub, 10 and, 11 not(A); in EXEC it SHALL equal opcode[1:0], in FETCH 00, otherwise 00.
REQ-008 States SHALL be IDLE, FETCH, DECODE, POP_A, POP_B, EXEC, WB, MEM_RD, PUSH_M, MEM_WR, JUMP, TOS_RD, BRZ; any output not listed for a state SHALL be 0.
REQ-009 IDLE: all outputs 0; next state FETCH.
REQ-010 FETCH: IorD=1, mem_read=1, IR_write=1, src_A=0, src_B=0, alu_op=00, pc_src=1, pc_write=1 (PC+1); next state DECODE.
REQ-011 DECODE: no outputs; next state POP_A for ADD/SUB/AND/NOT/POP, MEM_RD for PUSH, JUMP for JMP, TOS_RD for JZ.
REQ-012 POP_A: pop=1, ld_A=1; next state POP_B for ADD/SUB/AND, EXEC for NOT, MEM_WR for POP.
REQ-013 POP_B: pop=1, ld_B=1; next state EXEC.
REQ-014 EXEC: src_A=1, src_B=1, alu_op per REQ-007; next state WB.
REQ-015 WB: MtoS=1, push=1; next state FETCH.
REQ-016 MEM_RD: IorD=0, mem_read=1; next state PUSH_M.
REQ-017 PUSH_M: MtoS=0, push=1; next state FETCH.
REQ-018 MEM_WR: IorD=0, mem_write=1 (stores A); next state FETCH.
REQ-019 JUMP: pc_src=0, pc_write=1; next state FETCH.
REQ-020 TOS_RD: tos=1, loading the zero register; next state BRZ.
REQ-021 BRZ: pc_src=0, pc_write_cond=1; next state FETCH.
REQ-022 Per-instruction latency in cycles (FETCH inclusive) SHALL be: ADD/SUB/AND 6, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4.
REQ-023 push and pop SHALL never be high in the same cycle, and mem_read and mem_write SHALL never be high in the same cycle.
REQ-024 An unreachable state encoding SHALL transition to FETCH on the next cycle with all outputs 0.

Reset
REQ-025 rst=0 SHALL force state IDLE immediately, asynchronously, including mid-instruction, with all outputs 0 and instr_count=0.
REQ-026 The first FETCH SHALL occur on the second rising edge after rst deasserts.

Configuration
REQ-027 With CTRL_PERF_EN defined:
- instr_count SHALL increment by 1 on every transition into FETCH from WB, PUSH_M, MEM_WR, JUMP or BRZ.
- instr_count SHALL wrap from 0xFFFF to 0x0000.
REQ-028 Without CTRL_PERF_EN, the port and counter SHALL be absent and the FSM SHALL be unchanged.

Structure
REQ-029 A shared package ctrl_pkg SHALL hold the state enum (4-bit), the opcode constants and the alu_op constants.
REQ-030 The block SHALL have no sub-modules; the counter SHALL be inline.

Verification
REQ-031 Reset: rst low mid-EXEC -> all outputs 0 at once; IDLE, then FETCH with mem_read=IorD=IR_write=pc_write=1.
REQ-032 ADD: opcode=000 -> FETCH, DECODE, POP_A, POP_B, EXEC (alu_op=00, src_A=src_B=1), WB (push=1, MtoS=1); 6 cycles.
REQ-033 NOT/SUB: opcode=011 -> POP_B skipped, EXEC alu_op=11; opcode=001 -> EXEC alu_op=01.
REQ-034 PUSH then POP:
- PUSH: mem_read with IorD=0, then push with MtoS=0.
- POP: pop+ld_A, then mem_write=1 with IorD=0.
- Neither instruction asserts push and pop together.
REQ-035 JZ/JMP:
- opcode=111 -> tos=1, then pc_write_cond=1 with pc_src=0 and pc_write=0.
- opcode=110 -> pc_write=1 with pc_src=0.
REQ-036 CTRL_PERF_EN: 3 ADD + 2 JMP -> instr_count=5; preload 0xFFFF, then one instruction -> 0x0000.
